// File: rtl/trace_pkg.sv
// Shared definitions for the writeback trace capture path.
// Record layout (MSB first on the byte stream):
//   default      : {stamp[23:0], 3'b000, rd[4:0], data[31:0]}           64 bits, 8 bytes
//   TRACE_PC_EN  : {pc[31:0], stamp[23:0], 3'b000, rd[4:0], data[31:0]} 96 bits, 12 bytes
// Macro: TRACE_PC_EN selects the widened record that carries the fetch PC.
package trace_pkg;

    // The stamp width is fixed by the record format.
    localparam int STAMP_W = 24;

`ifdef TRACE_PC_EN
    localparam int REC_W     = 96;
    localparam int REC_BYTES = 12;
`else
    localparam int REC_W     = 64;
    localparam int REC_BYTES = 8;
`endif

    localparam logic [3:0] LAST_IDX = 4'(REC_BYTES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_e;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO with a first-word-fall-through read port.
// Ports:
//   clock, reset  rising-edge clock, asynchronous active-low reset
//   push, din     write a word (caller must not push into a full FIFO
//                 unless it pops in the same cycle)
//   pop, dout     dout shows the oldest word; pop advances past it
//   full, empty   occupancy flags
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign dout  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/wb_trace_capture.sv
// Writeback trace capture: timestamps register-file writebacks, queues them
// as records and streams each record MSB-first as a valid/ready byte stream.
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-low reset
//   enable                 capture enable (ignored writebacks are not drops)
//   dwb_write_reg/rt_rd/write_data  writeback strobe, destination, data
//   dif_pc_usable          fetch PC, recorded only when TRACE_PC_EN is defined
//   tx_data/tx_valid/tx_ready       byte stream toward the host link
//   overflow               sticky record-dropped flag
//   drop_count             saturating dropped-record count
// Macro: TRACE_PC_EN prepends the 32-bit PC to every record.
//
// state | meaning
// IDLE  | no record in the shift register; pops the FIFO as soon as it has one
// SEND  | presenting shift_q[MSB byte]; advances one byte per handshake
module wb_trace_capture
    import trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        dwb_write_reg,
    input  logic [4:0]  dwb_rt_rd,
    input  logic [31:0] dwb_write_data,
    input  logic [31:0] dif_pc_usable,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        overflow,
    output logic [7:0]  drop_count
);

    logic [STAMP_W-1:0] stamp_q;
    logic               overflow_q;
    logic [7:0]         drop_count_q;
    tx_state_e          state_q;
    logic [REC_W-1:0]   shift_q;
    logic [3:0]         byte_idx_q;
    logic               tx_valid_q;

    logic               capture;
    logic               last_hs;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [REC_W-1:0]   rec;
    logic [REC_W-1:0]   fifo_dout;

    assign capture = enable & dwb_write_reg & (dwb_rt_rd != 5'd0);

`ifdef TRACE_PC_EN
    assign rec = {dif_pc_usable, stamp_q, 3'b000, dwb_rt_rd, dwb_write_data};
`else
    assign rec = {stamp_q, 3'b000, dwb_rt_rd, dwb_write_data};
    logic unused_pc;
    assign unused_pc = ^dif_pc_usable;
`endif

    // A pop frees a slot in the same cycle, so a push into a full FIFO that
    // coincides with a pop is accepted rather than dropped.
    assign last_hs   = (state_q == SEND) & tx_ready & (byte_idx_q == LAST_IDX);
    assign fifo_pop  = ~fifo_empty & ((state_q == IDLE) | last_hs);
    assign fifo_push = capture & (~fifo_full | fifo_pop);

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (rec),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stamp_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            stamp_q <= stamp_q + 1'b1;
            if (capture && !fifo_push) begin
                overflow_q <= 1'b1;
                if (drop_count_q != 8'hFF) begin
                    drop_count_q <= drop_count_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            byte_idx_q <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        shift_q    <= fifo_dout;
                        byte_idx_q <= '0;
                        tx_valid_q <= 1'b1;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        if (byte_idx_q == LAST_IDX) begin
                            byte_idx_q <= '0;
                            if (!fifo_empty) begin
                                shift_q <= fifo_dout;
                            end else begin
                                // Cleared so tx_data idles at zero.
                                shift_q    <= '0;
                                tx_valid_q <= 1'b0;
                                state_q    <= IDLE;
                            end
                        end else begin
                            shift_q    <= shift_q << 8;
                            byte_idx_q <= byte_idx_q + 4'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_data    = shift_q[REC_W-1 -: 8];
    assign tx_valid   = tx_valid_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule
